// File: rtl/riscv_v_pipe_adder.sv
// rtl/riscv_v_pipe_adder.sv - SEW-segmented vector add/sub/min/max with reduction FSM
module riscv_v_pipe_adder #(
  parameter int DATA_W    = 128,
  parameter int NUM_BYTES = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic                 is_signed,
  input  logic [1:0]           osize,
  input  logic                 in_last,
  input  logic [DATA_W-1:0]    srca,
  input  logic [DATA_W-1:0]    srcb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    result,
  output logic [NUM_BYTES-1:0] ovf
);

  localparam int AW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {IDLE, ACCUM, FOLD, SEED, OUT_RED} state_e;

  state_e                state_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     result_q;
  logic [NUM_BYTES-1:0]  ovf_q;
  logic [DATA_W-1:0]     acc_q;
  logic [63:0]           seed_q;
  logic                  sticky_q;
  logic [2:0]            red_op_q;
  logic [1:0]            sew_q;
  logic                  sgn_q;
  logic [AW-1:0]         act_q;

  // Shared ALU operands, steered by the FSM state
  logic [DATA_W-1:0]     alu_a, alu_b, alu_res;
  logic [NUM_BYTES-1:0]  alu_ovf;
  logic [2:0]            alu_op;
  logic [1:0]            alu_sew;
  logic                  alu_sgn;
  logic [AW-1:0]         half_w;
  logic [DATA_W-1:0]     res_mask;
  logic [NUM_BYTES-1:0]  fold_ovf_mask;
  logic                  accept, in_is_red;

  function automatic logic [AW-1:0] sew_w(input logic [1:0] s);
    return AW'(8) << s;
  endfunction

  function automatic logic [63:0] seed_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Reduction ops reuse the element-wise ALU codes: REDSUM->ADD, REDMIN->MIN, REDMAX->MAX
  function automatic logic [2:0] red_alu_op(input logic [2:0] o);
    case (o)
      3'd5:    return 3'd2;
      3'd6:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  assign in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign in_is_red = op[2] && (op != 3'd7);
  assign half_w    = act_q >> 1;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

  // Operand steering and the masks used when folding and emitting the scalar
  always_comb begin
    alu_a   = srca;
    alu_b   = srcb;
    alu_op  = op;
    alu_sew = osize;
    alu_sgn = is_signed;
    case (state_q)
      ACCUM, OUT_RED: begin
        alu_a = acc_q; alu_op = red_op_q; alu_sew = sew_q; alu_sgn = sgn_q;
      end
      FOLD: begin
        alu_a = acc_q; alu_b = acc_q >> half_w;
        alu_op = red_op_q; alu_sew = sew_q; alu_sgn = sgn_q;
      end
      SEED: begin
        alu_a = DATA_W'(seed_q); alu_b = acc_q;
        alu_op = red_op_q; alu_sew = sew_q; alu_sgn = sgn_q;
      end
      default: ;
    endcase
    for (int i = 0; i < DATA_W; i++) res_mask[i] = (i < int'(sew_w(sew_q)));
    for (int i = 0; i < NUM_BYTES; i++) fold_ovf_mask[i] = ((i * 8) < int'(half_w));
  end

  logic [DATA_W-1:0]    res_by_sew [4];
  logic [NUM_BYTES-1:0] ovf_by_sew [4];

  // One lane-segmented ALU per SEW; carries never cross an element boundary
  for (genvar gs = 0; gs < 4; gs++) begin : g_sew
    localparam int W = 8 << gs;
    localparam int N = DATA_W / W;
    localparam int B = W / 8;
    for (genvar ge = 0; ge < N; ge++) begin : g_el
      logic [W-1:0] a, b, r;
      logic [W:0]   sum, diff;
      logic         lt, o;
      assign a = alu_a[ge*W +: W];
      assign b = alu_b[ge*W +: W];
      // Per-element add/sub/min/max with overflow detection
      always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        lt   = alu_sgn ? ($signed(a) < $signed(b)) : (a < b);
        r    = '0;
        o    = 1'b0;
        case (alu_op)
          3'd0: begin
            r = sum[W-1:0];
            o = alu_sgn ? ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1])) : sum[W];
          end
          3'd1: begin
            r = diff[W-1:0];
            o = alu_sgn ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1])) : diff[W];
          end
          3'd2:    r = lt ? a : b;
          3'd3:    r = lt ? b : a;
          default: ;
        endcase
      end
      assign res_by_sew[gs][ge*W +: W] = r;
      assign ovf_by_sew[gs][ge*B]      = o;
      if (B > 1) begin : g_zero
        assign ovf_by_sew[gs][ge*B+1 +: B-1] = '0;
      end
    end
  end

  assign alu_res = res_by_sew[alu_sew];
  assign alu_ovf = ovf_by_sew[alu_sew];

  // Control FSM with registered result, overflow and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= '0;
      acc_q       <= '0;
      seed_q      <= '0;
      sticky_q    <= 1'b0;
      red_op_q    <= '0;
      sew_q       <= '0;
      sgn_q       <= 1'b0;
      act_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (in_is_red) begin
            red_op_q <= red_alu_op(op);
            sew_q    <= osize;
            sgn_q    <= is_signed;
            acc_q    <= srcb;
            seed_q   <= srca[63:0] & seed_mask(osize);
            sticky_q <= 1'b0;
            act_q    <= AW'(DATA_W);
            if (!in_last)                            state_q <= ACCUM;
            else if (sew_w(osize) == AW'(DATA_W))    state_q <= SEED;
            else                                     state_q <= FOLD;
          end else begin
            result_q    <= alu_res;
            ovf_q       <= alu_ovf;
            out_valid_q <= 1'b1;
          end
        end
        ACCUM: if (accept) begin
          acc_q <= alu_res;
          if (red_op_q == 3'd0) sticky_q <= sticky_q | (|alu_ovf);
          if (in_last) state_q <= (sew_w(sew_q) == AW'(DATA_W)) ? SEED : FOLD;
        end
        FOLD: begin
          acc_q <= alu_res;
          act_q <= half_w;
          if (red_op_q == 3'd0) sticky_q <= sticky_q | (|(alu_ovf & fold_ovf_mask));
          if (half_w == sew_w(sew_q)) state_q <= SEED;
        end
        SEED: begin
          result_q    <= alu_res & res_mask;
          ovf_q       <= (red_op_q == 3'd0) ? NUM_BYTES'(sticky_q | alu_ovf[0]) : '0;
          out_valid_q <= 1'b1;
          state_q     <= OUT_RED;
        end
        OUT_RED: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_pipe_adder.sv
// tb/tb_riscv_v_pipe_adder.sv - directed table-driven bench for riscv_v_pipe_adder
module tb_riscv_v_pipe_adder;
  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, is_signed, in_last, out_valid, out_ready;
  logic [2:0]    op;
  logic [1:0]    osize;
  logic [DW-1:0] srca, srcb, result;
  logic [NB-1:0] ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]    op;
    logic          sgn;
    logic [1:0]    osz;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [NB-1:0] ovf;
  } vec_t;

  vec_t vecs[12];

  riscv_v_pipe_adder #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_signed(is_signed), .osize(osize), .in_last(in_last),
    .srca(srca), .srcb(srcb), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic s, input logic [1:0] z, input logic l,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1'b1; op = o; is_signed = s; osize = z; in_last = l; srca = a; srcb = b;
  endtask

  task automatic run_elem(input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    drive(v.op, v.sgn, v.osz, 1'b0, v.a, v.b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("elem_out_valid", DW'(out_valid), DW'(1));
    chk("elem_result", result, v.res);
    chk("elem_ovf", DW'(ovf), DW'(v.ovf));
  endtask

  task automatic red_beat(input logic [2:0] o, input logic s, input logic [1:0] z, input logic l,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    drive(o, s, z, l, a, b);
    #1 chk("red_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_red(input string name, input int lat, input logic [DW-1:0] exp_res,
                          input logic [NB-1:0] exp_ovf);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = i; seen = 1'b1;
        break;
      end
      chk({name, "_busy_in_ready"}, DW'(in_ready), DW'(0));
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no out_valid expected latency %0d", name, lat);
    end else begin
      chk({name, "_latency"}, DW'(n), DW'(lat));
      chk({name, "_result"}, result, exp_res);
      chk({name, "_ovf"}, DW'(ovf), DW'(exp_ovf));
      chk({name, "_outred_in_ready"}, DW'(in_ready), DW'(0));
      @(posedge clk); #1;
      chk({name, "_done_valid"}, DW'(out_valid), DW'(0));
      chk({name, "_done_in_ready"}, DW'(in_ready), DW'(1));
    end
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 2'd0, {16{8'hFF}}, {16{8'h01}}, 128'h0, 16'hFFFF};
    vecs[1]  = '{3'd1, 1'b1, 2'd1, 128'h8000, 128'h0001, 128'h7FFF, 16'h0001};
    vecs[2]  = '{3'd0, 1'b1, 2'd0, 128'hFF7F, 128'h0101, 128'h0080, 16'h0001};
    vecs[3]  = '{3'd0, 1'b0, 2'd3, {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h2, 64'h1},
                 {64'h3, 64'h0}, 16'h0001};
    vecs[4]  = '{3'd1, 1'b0, 2'd2, 128'h5_0000_0000, 128'h3_0000_0001, 128'h2_FFFF_FFFF, 16'h0001};
    vecs[5]  = '{3'd2, 1'b1, 2'd0, 128'h0180, 128'h7F01, 128'h0180, 16'h0000};
    vecs[6]  = '{3'd2, 1'b0, 2'd0, 128'h0180, 128'h7F01, 128'h0101, 16'h0000};
    vecs[7]  = '{3'd3, 1'b1, 2'd1, 128'h8000_FFFF, 128'h7FFF_0001, 128'h7FFF_0001, 16'h0000};
    vecs[8]  = '{3'd3, 1'b0, 2'd1, 128'h8000_FFFF, 128'h7FFF_0001, 128'h8000_FFFF, 16'h0000};
    vecs[9]  = '{3'd7, 1'b0, 2'd0, {16{8'hFF}}, {16{8'h01}}, 128'h0, 16'h0000};
    vecs[10] = '{3'd1, 1'b1, 2'd0, 128'h7F, 128'hFF, 128'h80, 16'h0001};
    vecs[11] = '{3'd1, 1'b0, 2'd3, {64'h5, 64'h0}, {64'h0, 64'h1},
                 {64'h5, 64'hFFFF_FFFF_FFFF_FFFF}, 16'h0001};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; is_signed = 1'b0;
    osize = '0; in_last = 1'b0; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_result", result, '0);
    chk("rst_ovf", DW'(ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", DW'(in_ready), DW'(1));

    for (int i = 0; i < 12; i++) run_elem(vecs[i]);
    @(posedge clk); #1;
    chk("elem_drain_valid", DW'(out_valid), DW'(0));

    // back-to-back: second request issued while first result is consumed
    @(negedge clk);
    drive(vecs[2].op, vecs[2].sgn, vecs[2].osz, 1'b0, vecs[2].a, vecs[2].b);
    @(posedge clk); #1;
    drive(vecs[7].op, vecs[7].sgn, vecs[7].osz, 1'b0, vecs[7].a, vecs[7].b);
    chk("b2b_first", result, vecs[2].res);
    chk("b2b_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_second", result, vecs[7].res);
    chk("b2b_valid", DW'(out_valid), DW'(1));
    @(posedge clk); #1;

    // backpressure with a pending request waiting behind the stalled result
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[4].op, vecs[4].sgn, vecs[4].osz, 1'b0, vecs[4].a, vecs[4].b);
    @(posedge clk); #1;
    drive(vecs[0].op, vecs[0].sgn, vecs[0].osz, 1'b0, vecs[0].a, vecs[0].b);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", DW'(out_valid), DW'(1));
      chk("bp_result", result, vecs[4].res);
      chk("bp_ovf", DW'(ovf), DW'(vecs[4].ovf));
      chk("bp_in_ready", DW'(in_ready), DW'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", DW'(out_valid), DW'(1));
    chk("bp_next_result", result, vecs[0].res);
    chk("bp_next_ovf", DW'(ovf), DW'(vecs[0].ovf));
    @(posedge clk); #1;
    chk("bp_drain_valid", DW'(out_valid), DW'(0));

    // REDSUM SEW32, seed 10, two beats; op/osize on second beat must be ignored
    red_beat(3'd4, 1'b0, 2'd2, 1'b0, 128'hFFFF_FFFF_0000_000A,
             128'h00000004_00000003_00000002_00000001);
    red_beat(3'd0, 1'b1, 2'd0, 1'b1, 128'h0,
             128'h00000004_00000003_00000002_00000001);
    wait_red("redsum32", 3, 128'd30, 16'h0000);

    // REDMAX signed SEW8 single beat
    red_beat(3'd6, 1'b1, 2'd0, 1'b1, 128'h05, 128'h7F80);
    wait_red("redmax8", 5, 128'h7F, 16'h0000);

    // REDMIN signed SEW16, seed bits above SEW ignored
    red_beat(3'd5, 1'b1, 2'd1, 1'b1, 128'hABCD_0003, 128'hFFF0_0005);
    wait_red("redmin16", 4, 128'hFFF0, 16'h0000);

    // REDSUM with carry-out in the accumulate step, sticky into ovf[0]
    red_beat(3'd4, 1'b0, 2'd0, 1'b0, 128'h0, 128'hFF);
    red_beat(3'd4, 1'b0, 2'd0, 1'b1, 128'h0, 128'h01);
    wait_red("redsum_ovf", 5, 128'h0, 16'h0001);

    // reset in the middle of FOLD abandons the reduction
    red_beat(3'd4, 1'b0, 2'd0, 1'b1, 128'h33, {16{8'h11}});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstfold_valid", DW'(out_valid), DW'(0));
    chk("rstfold_result", result, '0);
    chk("rstfold_ovf", DW'(ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstfold_in_ready", DW'(in_ready), DW'(1));
    begin
      int seen_v = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen_v++;
      end
      chk("rstfold_no_emit", DW'(seen_v), DW'(0));
    end
    red_beat(3'd4, 1'b0, 2'd0, 1'b1, 128'h02, {16{8'h01}});
    wait_red("redsum_after_rst", 5, 128'h12, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
